// File: rtl/fifo_rr_scheduler.sv
// Round-robin scheduler that drains NUM_CH source fifos into one downstream fifo.
// One source is popped per cycle at most; the popped word is pushed downstream one
// cycle later, once the source fifo has presented it on its registered output.
module fifo_rr_scheduler #(
  parameter int BUS_SIZE  = 5,
  parameter int NUM_CH    = 4,
  parameter int ID_W      = 2,
  parameter int CNT_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       clear_cnt,
  input  logic [NUM_CH-1:0]          empty_in,
  input  logic [NUM_CH*BUS_SIZE-1:0] data_in,
  input  logic                       pause_in,
  output logic [NUM_CH-1:0]          pop,
  output logic                       push,
  output logic [BUS_SIZE-1:0]        data_out,
  output logic [ID_W-1:0]            grant_id,
  output logic                       idle,
  output logic [CNT_WIDTH-1:0]       pkt_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     grant;
  logic [ID_W-1:0]     grant_d1;
  logic [ID_W-1:0]     search_idx;
  logic [ID_W-1:0]     next_ptr;
  logic                found;
  logic                pop_ok;
  logic                pop_d1;
  logic                any_ready;
  logic [BUS_SIZE-1:0] ch_data [NUM_CH];

  // Split the packed source bus into one word per channel.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign ch_data[i] = data_in[i*BUS_SIZE +: BUS_SIZE];
  end

  assign any_ready = ~&empty_in;
  assign pop_ok    = (state == ACTIVE) && enable && !pause_in && found;
  assign next_ptr  = (grant == ID_W'(NUM_CH - 1)) ? '0 : grant + ID_W'(1);

  assign push      = pop_d1;
  assign data_out  = pop_d1 ? ch_data[grant_d1] : '0;
  assign grant_id  = grant_d1;
  assign idle      = (state == IDLE);

  // Find the first non-empty channel starting at the round-robin pointer.
  always_comb begin
    grant      = '0;
    found      = 1'b0;
    search_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      search_idx = ID_W'((int'(rr_ptr) + k) % NUM_CH);
      if (!found && !empty_in[search_idx]) begin
        found = 1'b1;
        grant = search_idx;
      end
    end
  end

  // Drive a one-hot pop to the granted channel when issue is allowed this cycle.
  always_comb begin
    pop = '0;
    if (pop_ok) begin
      pop[grant] = 1'b1;
    end
  end

  // Scheduler state machine: pause holds issue, loss of enable or work returns to idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (enable && !pause_in && any_ready) begin
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (pause_in) begin
            state <= PAUSED;
          end else if (!enable || !any_ready) begin
            state <= IDLE;
          end
        end
        PAUSED: begin
          if (!enable) begin
            state <= IDLE;
          end else if (!pause_in) begin
            state <= ACTIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Advance the pointer past the granted channel and remember the pop for the push stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= '0;
      pop_d1   <= 1'b0;
      grant_d1 <= '0;
    end else begin
      pop_d1 <= pop_ok;
      if (pop_ok) begin
        rr_ptr   <= next_ptr;
        grant_d1 <= grant;
      end
    end
  end

  // Count pushed words, saturating at all-ones; a clear wins over a concurrent push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_count <= '0;
    end else if (clear_cnt) begin
      pkt_count <= '0;
    end else if (pop_d1 && (pkt_count != '1)) begin
      pkt_count <= pkt_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed testbench for fifo_rr_scheduler with simple behavioural source fifos.
module tb_fifo_rr_scheduler;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        clear_cnt;
  logic [3:0]  empty_in;
  logic [19:0] data_in;
  logic        pause_in;
  logic [3:0]  pop;
  logic        push;
  logic [4:0]  data_out;
  logic [1:0]  grant_id;
  logic        idle;
  logic [4:0]  pkt_count;

  logic        fifo_init;
  logic [4:0]  mem [4][64];
  logic [4:0]  data_reg [4];
  int          rd [4];
  int          wr [4];

  int pass_cnt;
  int total_cnt;

  fifo_rr_scheduler #(
    .BUS_SIZE(5), .NUM_CH(4), .ID_W(2), .CNT_WIDTH(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .clear_cnt(clear_cnt),
    .empty_in(empty_in),
    .data_in(data_in),
    .pause_in(pause_in),
    .pop(pop),
    .push(push),
    .data_out(data_out),
    .grant_id(grant_id),
    .idle(idle),
    .pkt_count(pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source fifos: registered read, word appears on data_reg the cycle after pop.
  always @(posedge clk) begin
    if (fifo_init) begin
      for (int i = 0; i < 4; i++) begin
        rd[i]       <= 0;
        data_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pop[i]) begin
          data_reg[i] <= mem[i][6'(rd[i])];
          rd[i]       <= rd[i] + 1;
        end
      end
    end
  end

  // Empty flag of each source fifo.
  always_comb begin
    empty_in = '1;
    for (int i = 0; i < 4; i++) begin
      empty_in[i] = (rd[i] == wr[i]);
    end
  end

  assign data_in = {data_reg[3], data_reg[2], data_reg[1], data_reg[0]};

  task automatic load(input int ch, input logic [4:0] word);
    mem[ch][6'(wr[ch])] = word;
    wr[ch] = wr[ch] + 1;
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) wr[i] = rd[i];
  endtask

  task automatic do_reset();
    @(negedge clk);
    enable    = 1'b0;
    pause_in  = 1'b0;
    clear_cnt = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    flush();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) load(i, 5'(i + 3));
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    total_cnt++;
    if (pop !== 4'b0000) $display("[TB] FAIL reset_pop got %b want 0000", pop); else pass_cnt++;
    total_cnt++;
    if (push !== 1'b0) $display("[TB] FAIL reset_push got %b want 0", push); else pass_cnt++;
    total_cnt++;
    if (data_out !== 5'h00) $display("[TB] FAIL reset_data got %h want 00", data_out); else pass_cnt++;
    total_cnt++;
    if (pkt_count !== 5'd0) $display("[TB] FAIL reset_count got %0d want 0", pkt_count); else pass_cnt++;
    total_cnt++;
    if (idle !== 1'b1) $display("[TB] FAIL reset_idle got %b want 1", idle); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_round_robin();
    logic [3:0] ep [6] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0000, 4'b0000};
    logic       eh [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0] ed [6] = '{5'h00, 5'h01, 5'h11, 5'h02, 5'h12, 5'h00};
    logic [1:0] eg [6] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0};
    do_reset();
    load(0, 5'h01); load(0, 5'h02);
    load(2, 5'h11); load(2, 5'h12);
    @(negedge clk);
    enable = 1'b1;
    #1;
    total_cnt++;
    if (pop !== 4'b0000) $display("[TB] FAIL rr_idle_pop got %b want 0000", pop); else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      total_cnt++;
      if (pop !== ep[k]) $display("[TB] FAIL rr_pop[%0d] got %b want %b", k, pop, ep[k]); else pass_cnt++;
      total_cnt++;
      if (push !== eh[k]) $display("[TB] FAIL rr_push[%0d] got %b want %b", k, push, eh[k]); else pass_cnt++;
      total_cnt++;
      if (data_out !== ed[k]) $display("[TB] FAIL rr_data[%0d] got %h want %h", k, data_out, ed[k]); else pass_cnt++;
      if (eh[k]) begin
        total_cnt++;
        if (grant_id !== eg[k]) $display("[TB] FAIL rr_grant[%0d] got %0d want %0d", k, grant_id, eg[k]); else pass_cnt++;
      end
    end
    total_cnt++;
    if (pkt_count !== 5'd4) $display("[TB] FAIL rr_count got %0d want 4", pkt_count); else pass_cnt++;
    total_cnt++;
    if (idle !== 1'b1) $display("[TB] FAIL rr_idle_end got %b want 1", idle); else pass_cnt++;
  endtask

  task automatic test_pause();
    logic       pz [14] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [3:0] ep [14] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100,
                            4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    logic       eh [14] = '{0, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
    logic [4:0] ed [14] = '{5'h00, 5'h01, 5'h09, 5'h00, 5'h00, 5'h00, 5'h00,
                            5'h11, 5'h19, 5'h02, 5'h0A, 5'h12, 5'h1A, 5'h00};
    logic [1:0] eg [14] = '{0, 0, 1, 0, 0, 0, 0, 2, 3, 0, 1, 2, 3, 0};
    do_reset();
    load(0, 5'h01); load(0, 5'h02);
    load(1, 5'h09); load(1, 5'h0A);
    load(2, 5'h11); load(2, 5'h12);
    load(3, 5'h19); load(3, 5'h1A);
    @(negedge clk);
    enable = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      pause_in = pz[k];
      #1;
      total_cnt++;
      if (pop !== ep[k]) $display("[TB] FAIL pause_pop[%0d] got %b want %b", k, pop, ep[k]); else pass_cnt++;
      total_cnt++;
      if (push !== eh[k]) $display("[TB] FAIL pause_push[%0d] got %b want %b", k, push, eh[k]); else pass_cnt++;
      total_cnt++;
      if (data_out !== ed[k]) $display("[TB] FAIL pause_data[%0d] got %h want %h", k, data_out, ed[k]); else pass_cnt++;
      if (eh[k]) begin
        total_cnt++;
        if (grant_id !== eg[k]) $display("[TB] FAIL pause_grant[%0d] got %0d want %0d", k, grant_id, eg[k]); else pass_cnt++;
      end
      if (k >= 3 && k <= 5) begin
        total_cnt++;
        if (idle !== 1'b0) $display("[TB] FAIL pause_state[%0d] idle got %b want 0", k, idle); else pass_cnt++;
      end
    end
    total_cnt++;
    if (pkt_count !== 5'd8) $display("[TB] FAIL pause_count got %0d want 8", pkt_count); else pass_cnt++;
  endtask

  task automatic test_enable_drop();
    logic       en [4] = '{1, 1, 0, 0};
    logic [3:0] ep [4] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000};
    logic       eh [4] = '{0, 1, 1, 0};
    logic [4:0] ed [4] = '{5'h00, 5'h05, 5'h06, 5'h00};
    logic       ei [4] = '{0, 0, 0, 1};
    do_reset();
    load(1, 5'h05); load(1, 5'h06); load(1, 5'h07);
    @(negedge clk);
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      enable = en[k];
      #1;
      total_cnt++;
      if (pop !== ep[k]) $display("[TB] FAIL endrop_pop[%0d] got %b want %b", k, pop, ep[k]); else pass_cnt++;
      total_cnt++;
      if (push !== eh[k]) $display("[TB] FAIL endrop_push[%0d] got %b want %b", k, push, eh[k]); else pass_cnt++;
      total_cnt++;
      if (data_out !== ed[k]) $display("[TB] FAIL endrop_data[%0d] got %h want %h", k, data_out, ed[k]); else pass_cnt++;
      total_cnt++;
      if (idle !== ei[k]) $display("[TB] FAIL endrop_idle[%0d] got %b want %b", k, idle, ei[k]); else pass_cnt++;
      if (eh[k]) begin
        total_cnt++;
        if (grant_id !== 2'd1) $display("[TB] FAIL endrop_grant[%0d] got %0d want 1", k, grant_id); else pass_cnt++;
      end
    end
    total_cnt++;
    if (pkt_count !== 5'd2) $display("[TB] FAIL endrop_count got %0d want 2", pkt_count); else pass_cnt++;
  endtask

  task automatic test_saturation();
    int         seen;
    logic [4:0] exp_word;
    seen = 0;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      load(0, 5'(k));
      load(3, 5'(k + 12));
    end
    @(negedge clk);
    enable = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      #1;
      total_cnt++;
      if (!$onehot0(pop) || ((pop & empty_in) != 4'b0000))
        $display("[TB] FAIL sat_pop_legal[%0d] got pop=%b empty=%b want onehot0 non-empty", c, pop, empty_in);
      else pass_cnt++;
      if (push === 1'b1) begin
        exp_word = (seen % 2 == 0) ? 5'(seen / 2) : 5'(12 + seen / 2);
        total_cnt++;
        if (data_out !== exp_word) $display("[TB] FAIL sat_data[%0d] got %h want %h", seen, data_out, exp_word); else pass_cnt++;
        seen++;
      end
    end
    total_cnt++;
    if (seen != 40) $display("[TB] FAIL sat_push_total got %0d want 40", seen); else pass_cnt++;
    total_cnt++;
    if (pkt_count !== 5'd31) $display("[TB] FAIL sat_count got %0d want 31", pkt_count); else pass_cnt++;
    clear_cnt = 1'b1;
    @(negedge clk);
    clear_cnt = 1'b0;
    #1;
    total_cnt++;
    if (pkt_count !== 5'd0) $display("[TB] FAIL sat_clear got %0d want 0", pkt_count); else pass_cnt++;
    enable = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    load(2, 5'h15);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    #1;
    total_cnt++;
    if (pop !== 4'b0100) $display("[TB] FAIL areset_pop got %b want 0100", pop); else pass_cnt++;
    @(posedge clk);
    #3;
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      total_cnt++;
      if (push !== 1'b0) $display("[TB] FAIL areset_push[%0d] got %b want 0", c, push); else pass_cnt++;
      total_cnt++;
      if (data_out !== 5'h00) $display("[TB] FAIL areset_data[%0d] got %h want 00", c, data_out); else pass_cnt++;
    end
    reset = 1'b1;
    load(1, 5'h04);
    load(3, 5'h1C);
    @(negedge clk);
    #1;
    total_cnt++;
    if (pop !== 4'b0010) $display("[TB] FAIL areset_ptr got %b want 0010", pop); else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (push !== 1'b1 || data_out !== 5'h04)
      $display("[TB] FAIL areset_next_push got push=%b data=%h want push=1 data=04", push, data_out);
    else pass_cnt++;
    total_cnt++;
    if (pop !== 4'b1000) $display("[TB] FAIL areset_next_pop got %b want 1000", pop); else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (push !== 1'b1 || data_out !== 5'h1C)
      $display("[TB] FAIL areset_last_push got push=%b data=%h want push=1 data=1c", push, data_out);
    else pass_cnt++;
    enable = 1'b0;
  endtask

  // Main sequence of directed scenarios.
  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    enable    = 1'b0;
    clear_cnt = 1'b0;
    pause_in  = 1'b0;
    fifo_init = 1'b1;
    for (int i = 0; i < 4; i++) wr[i] = 0;
    #1;
    reset = 1'b0;
    @(negedge clk);
    fifo_init = 1'b0;
    test_reset();
    test_round_robin();
    test_pause();
    test_enable_drop();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
